// File: rtl/adc_phs_pkg.sv
// adc_phs_pkg: shared FSM states, command/status field positions and status helpers for the ADC phase sequencer.
package adc_phs_pkg;
  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT, S_GAP} state_t;
  localparam int CMD_GO = 31;
  localparam int CMD_DIR = 30;
  localparam int CMD_N_MSB = 15;
  localparam int ST_BUSY = 31;
  localparam int ST_ERR_TO = 30;
  localparam int ST_ERR_OV = 29;
  localparam int ST_SL_LSB = 16;
  localparam int SL_W = 11;
  function automatic logic [SL_W-1:0] sat_steps(input logic [15:0] s);
    return |s[15:SL_W] ? '1 : s[SL_W-1:0];
  endfunction
endpackage

// File: rtl/phs_pos_wrap.sv
// phs_pos_wrap: modulo-MOD up/down position counter, wraps in [0, MOD-1].
module phs_pos_wrap #(
  parameter int MOD = 1120,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] pos
);
  localparam logic [W-1:0] TOP = W'(MOD - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) pos <= '0;
    else if (en) pos <= up ? (pos == TOP ? '0 : pos + 1'b1) : (pos == '0 ? TOP : pos - 1'b1);
endmodule

// File: rtl/adc_in_inc_phs_seq.sv
// adc_in_inc_phs_seq: turns toggled software commands into MMCM fine phase-shift steps and tracks position.
module adc_in_inc_phs_seq
  import adc_phs_pkg::*;
#(
  parameter int PHASE_MOD = 1120,
  parameter int TIMEOUT = 255,
  parameter int GAP_CYCLES = 4
) (
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic [31:0] cmd_word,
  output logic        ps_en,
  output logic        ps_incdec,
  input  logic        ps_done,
  output logic        busy,
  output logic [31:0] status_word
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  logic [1:0] rst_q;
  logic rst, armed, go_q, dir_in, go_last, dir, err_to, err_ov;
  logic toggle, accept, step_ok, tmo, gap_end, unused_cmd;
  logic [15:0] n_in, steps_left, pos;
  logic [TW-1:0] wcnt;
  logic [GW-1:0] gcnt;
  state_t state, state_nxt;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge user_clk or posedge user_rst)
    if (user_rst) rst_q <= 2'b11;
    else rst_q <= {rst_q[0], 1'b0};
  assign rst = rst_q[1];

  assign unused_cmd = ^cmd_word[29:16];
  assign toggle = armed && go_q != go_last;
  assign accept = state == S_IDLE && toggle;
  assign step_ok = state == S_WAIT && ps_done;
  assign tmo = state == S_WAIT && !ps_done && wcnt == TW'(TIMEOUT - 1);
  assign gap_end = state == S_GAP && gcnt == GW'(GAP_CYCLES - 1);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  state_nxt = accept && n_in != '0 ? S_PULSE : S_IDLE;
      S_PULSE: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = step_ok ? S_GAP : tmo ? S_IDLE : S_WAIT;
      S_GAP:   state_nxt = !gap_end ? S_GAP : steps_left != '0 ? S_PULSE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge user_clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      armed <= 1'b0;
      go_q <= 1'b0;
      dir_in <= 1'b0;
      n_in <= '0;
      go_last <= 1'b0;
      dir <= 1'b0;
      err_to <= 1'b0;
      err_ov <= 1'b0;
      steps_left <= '0;
      wcnt <= '0;
      gcnt <= '0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      go_q <= cmd_word[CMD_GO];
      dir_in <= cmd_word[CMD_DIR];
      n_in <= cmd_word[CMD_N_MSB:0];
      // The first sampled toggle level becomes the reference so release never starts a run.
      if (!armed || toggle) go_last <= !armed ? cmd_word[CMD_GO] : go_q;
      if (accept) begin
        dir <= dir_in;
        steps_left <= n_in;
        err_to <= 1'b0;
        err_ov <= 1'b0;
      end else if (toggle) err_ov <= 1'b1;
      if (step_ok) steps_left <= steps_left - 1'b1;
      if (tmo) begin
        err_to <= 1'b1;
        steps_left <= '0;
      end
      // wcnt holds the number of cycles elapsed since the PSEN pulse.
      wcnt <= state == S_WAIT ? wcnt + 1'b1 : TW'(1);
      gcnt <= state == S_GAP ? gcnt + 1'b1 : '0;
    end

  phs_pos_wrap #(.MOD(PHASE_MOD), .W(16)) u_pos (
    .clk(user_clk),
    .rst(rst),
    .en(step_ok),
    .up(dir),
    .pos(pos)
  );

  assign ps_en = state == S_PULSE;
  assign ps_incdec = dir;
  assign busy = state != S_IDLE;

  always_comb begin
    status_word = '0;
    status_word[ST_BUSY] = busy;
    status_word[ST_ERR_TO] = err_to;
    status_word[ST_ERR_OV] = err_ov;
    status_word[ST_SL_LSB +: SL_W] = sat_steps(steps_left);
    status_word[15:0] = pos;
  end
endmodule

// File: tb/tb_adc_in_inc_phs_seq.sv
// tb_adc_in_inc_phs_seq: scoreboard bench with an MMCM PSDONE model for the phase-shift sequencer.
module tb_adc_in_inc_phs_seq;
  logic user_clk = 1'b0;
  logic user_rst, ps_en, ps_incdec, ps_done, busy;
  logic [31:0] cmd_word, status_word;
  typedef struct packed {logic d; logic [15:0] pos;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0, psen_cnt = 0, drop_at = 0, t, seen;
  logic [15:0] pos_m = '0, pend_pos = '0;
  logic pend = 1'b0, pend_dir = 1'b0, chk_pos = 1'b0;

  always #5 user_clk = ~user_clk;

  adc_in_inc_phs_seq dut (
    .user_clk(user_clk),
    .user_rst(user_rst),
    .cmd_word(cmd_word),
    .ps_en(ps_en),
    .ps_incdec(ps_incdec),
    .ps_done(ps_done),
    .busy(busy),
    .status_word(status_word)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] nxt(input logic [15:0] p, input logic d);
    if (d) return p == 16'd1119 ? 16'd0 : p + 16'd1;
    return p == 16'd0 ? 16'd1119 : p - 16'd1;
  endfunction

  function automatic logic [31:0] st(input bit b, input bit eto, input bit eov, input int sl, input int p);
    return {b, eto, eov, 2'b00, sl[10:0], p[15:0]};
  endfunction

  // MMCM model: PSDONE 12 cycles after PSEN, except for the pulse numbered drop_at.
  initial begin
    ps_done = 1'b0;
    forever begin
      @(negedge user_clk);
      if (ps_en === 1'b1) begin
        psen_cnt++;
        if (psen_cnt != drop_at) begin
          repeat (12) @(negedge user_clk);
          ps_done = 1'b1;
          @(negedge user_clk);
          ps_done = 1'b0;
        end
      end
    end
  end

  initial begin
    exp_t it;
    forever begin
      @(negedge user_clk);
      if (chk_pos) begin
        chk("pos", status_word[15:0], pend_pos);
        chk_pos = 1'b0;
      end
      if (ps_en === 1'b1) begin
        if (sb.size() == 0) chk("unexp_psen", ps_en, 0);
        else begin
          it = sb.pop_front();
          chk("incdec", ps_incdec, it.d);
          pend_pos = it.pos;
          pend_dir = it.d;
          pend = 1'b1;
        end
      end
      if (ps_done && pend) begin
        chk("incdec_hold", ps_incdec, pend_dir);
        chk_pos = 1'b1;
        pend = 1'b0;
      end
    end
  end

  task automatic do_reset();
    user_rst = 1'b1;
    #1;
    chk("rst_en", ps_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_incdec", ps_incdec, 0);
    chk("rst_status", status_word, 0);
    pend = 1'b0;
    chk_pos = 1'b0;
    sb.delete();
    pos_m = '0;
    repeat (2) @(negedge user_clk);
    user_rst = 1'b0;
    repeat (4) @(negedge user_clk);
  endtask

  task automatic go(input bit d, input int n, input int npush);
    cmd_word = {~cmd_word[31], d, 14'b0, n[15:0]};
    for (int i = 0; i < npush; i++) begin
      pos_m = nxt(pos_m, d);
      sb.push_back('{d, pos_m});
    end
    @(negedge user_clk);
    chk("lat_a", ps_en, 0);
    @(negedge user_clk);
    chk("lat_b", ps_en, n != 0);
  endtask

  task automatic wait_idle(input int budget, output int cyc);
    cyc = 0;
    while (busy && cyc < budget) begin
      @(negedge user_clk);
      cyc++;
    end
    chk("idle", busy, 0);
  endtask

  initial begin
    cmd_word = '0;
    do_reset();
    // inc by 3; run length covers 3 steps of 1+12+4 cycles
    go(1, 3, 3);
    chk("t1_run", status_word, st(1, 0, 0, 3, 0));
    wait_idle(400, t);
    chk("t1_len", t, 51);
    chk("t1_st", status_word, st(0, 0, 0, 0, 3));
    do_reset();
    // dec wraps below zero
    go(0, 2, 2);
    wait_idle(400, t);
    chk("t2_st", status_word, st(0, 0, 0, 0, 1118));
    do_reset();
    // second PSDONE dropped
    drop_at = psen_cnt + 2;
    go(1, 5, 2);
    seen = 1;
    for (int k = 0; k < 300 && seen < 2; k++) begin
      @(negedge user_clk);
      if (ps_en) seen++;
    end
    for (t = 1; t <= 400; t++) begin
      @(negedge user_clk);
      if (status_word[30]) break;
    end
    chk("t4_lat", t, 255);
    chk("t4_st", status_word, st(0, 1, 0, 0, 1));
    pend = 1'b0;
    pos_m = 16'd1;
    repeat (40) @(negedge user_clk);
    chk("t4_sb", sb.size(), 0);
    // zero-length command only clears errors
    go(0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge user_clk);
      chk("t3_busy", busy, 0);
    end
    chk("t3_st", status_word, st(0, 0, 0, 0, 1));
    // overrun toggle mid-run
    go(1, 10, 10);
    repeat (30) @(negedge user_clk);
    cmd_word[31] = ~cmd_word[31];
    wait_idle(400, t);
    chk("t5_st", status_word, st(0, 0, 1, 0, 11));
    chk("t5_sb", sb.size(), 0);
    go(1, 1, 1);
    wait_idle(100, t);
    chk("t5_clr", status_word, st(0, 0, 0, 0, 12));
    // huge step count saturates in status, then times out
    drop_at = psen_cnt + 1;
    go(0, 16'hFFFF, 1);
    chk("sat_st", status_word, st(1, 0, 0, 11'h7FF, 12));
    wait_idle(400, t);
    chk("sat_end", status_word, st(0, 1, 0, 0, 12));
    pend = 1'b0;
    pos_m = 16'd12;
    // reset mid-WAIT, stray PSDONE arrives afterwards
    go(1, 5, 5);
    chk("t6_run", status_word, st(1, 0, 0, 5, 12));
    repeat (3) @(negedge user_clk);
    do_reset();
    repeat (20) @(negedge user_clk);
    chk("t6_st", status_word, 0);
    chk("t6_sb", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
